pll_reset_sequencer: RTL and testbench

- Consumes the PLL lock indication and the board system clock.
- Produces the design's reset tree: a system reset, and a CPU reset released in step with the 6809 bus clocks.
- Generates the 6809 E/Q quadrature clock enables from the single system clock.
- Sits between the clock-generation wrapper and the CPU/memory top level. The CPU is never released before the clocks are stable.

---
 rtl/rseq_pkg.sv | 32 +++
 rtl/eq_phase_gen.sv | 75 +++++++
 rtl/pll_reset_sequencer.sv | 158 +++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rseq_pkg.sv
// Shared definitions for pll_reset_sequencer: FSM state encoding,
// E/Q phase codes and the phase-to-clock-level decode.
package rseq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_FILTER    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } rseq_state_e;

  typedef logic [1:0] phase_t;

  // Quadrature order 3->0->1->2->3: Q rises one quarter ahead of E.
  localparam phase_t PH_Q_HI = 2'd0;
  localparam phase_t PH_BOTH = 2'd1;
  localparam phase_t PH_E_HI = 2'd2;
  localparam phase_t PH_IDLE = 2'd3;

  typedef struct packed {
    logic e;
    logic q;
  } eq_t;

  function automatic eq_t eq_decode(input phase_t ph);
    eq_t r;
    r.e = (ph == PH_BOTH) || (ph == PH_E_HI);
    r.q = (ph == PH_Q_HI) || (ph == PH_BOTH);
    return r;
  endfunction

endpackage

// File: rtl/eq_phase_gen.sv
// 6809 E/Q quadrature generator: DIV clocks per quarter, registered E/Q and
// edge strobes. i_clr parks the generator at phase 3 with no strobes.
module eq_phase_gen
  import rseq_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_en,
  input  logic i_clr,
  output logic o_e,
  output logic o_q,
  output logic o_e_rise,
  output logic o_e_fall,
  output logic o_fall_evt
);

  localparam int QW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(DIV - 1);

  logic [QW-1:0] r_qcnt;
  logic [QW-1:0] w_qcnt_next;
  phase_t        r_phase;
  phase_t        w_phase_next;
  eq_t           w_eq_next;
  logic          w_wrap;
  logic          w_rise_evt;
  logic          r_e;
  logic          r_q;
  logic          r_e_rise;
  logic          r_e_fall;

  // Kept independent of i_clr so the FSM can consume it without a comb loop.
  assign o_fall_evt = i_en && (r_qcnt == Q_LAST) && (r_phase == PH_E_HI);

  always_comb begin
    w_wrap       = i_en && !i_clr && (r_qcnt == Q_LAST);
    w_qcnt_next  = r_qcnt;
    w_phase_next = r_phase;
    if (i_clr) begin
      w_qcnt_next  = '0;
      w_phase_next = PH_IDLE;
    end else if (i_en) begin
      w_qcnt_next = w_wrap ? '0 : r_qcnt + QW'(1);
      if (w_wrap) w_phase_next = r_phase + 2'd1;
    end
    w_rise_evt = w_wrap && (r_phase == PH_Q_HI);
    w_eq_next  = eq_decode(w_phase_next);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_qcnt   <= '0;
      r_phase  <= PH_IDLE;
      r_e      <= 1'b0;
      r_q      <= 1'b0;
      r_e_rise <= 1'b0;
      r_e_fall <= 1'b0;
    end else begin
      r_qcnt   <= w_qcnt_next;
      r_phase  <= w_phase_next;
      r_e      <= w_eq_next.e;
      r_q      <= w_eq_next.q;
      r_e_rise <= w_rise_evt;
      r_e_fall <= w_wrap && (r_phase == PH_E_HI);
    end
  end

  assign o_e      = r_e;
  assign o_q      = r_q;
  assign o_e_rise = r_e_rise;
  assign o_e_fall = r_e_fall;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL lock filter and reset sequencer: releases SYS_RESET after a stable lock,
// then CPU_RESET_N in step with E falling. RSEQ_LOCK_MONITOR_EN adds LOSS_COUNT.
module pll_reset_sequencer
  import rseq_pkg::*;
#(
  parameter int LOCK_FILTER_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int DIV                = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LOCKED,
  output logic       SYS_RESET,
  output logic       CPU_RESET_N,
  output logic       E,
  output logic       Q,
  output logic       E_RISE,
  output logic       E_FALL,
`ifdef RSEQ_LOCK_MONITOR_EN
  output logic [7:0] LOSS_COUNT,
`endif
  output logic       READY
);

  localparam int FW = (LOCK_FILTER_CYCLES > 1) ? $clog2(LOCK_FILTER_CYCLES) : 1;
  localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

  logic [1:0]    r_lock_sync;
  logic          w_locked_s;
  rseq_state_e   r_state;
  rseq_state_e   w_state_next;
  logic [FW-1:0] r_filter_cnt;
  logic [FW-1:0] w_filter_cnt_next;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_cnt_next;
  logic          w_active;
  logic          w_gen_clr;
  logic          w_fall_evt;
  logic          w_sys_reset_d;
  logic          w_cpu_reset_n_d;
  logic          w_ready_d;
  logic          r_sys_reset;
  logic          r_cpu_reset_n;
  logic          r_ready;

  assign w_locked_s = r_lock_sync[1];
  assign w_active   = (r_state == ST_HOLD) || (r_state == ST_RUN);
  // Lock loss parks the generator on the same edge the resets reassert.
  assign w_gen_clr  = !(w_active && w_locked_s);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_lock_sync   <= 2'b00;
      r_state       <= ST_WAIT_LOCK;
      r_filter_cnt  <= '0;
      r_hold_cnt    <= '0;
      r_sys_reset   <= 1'b1;
      r_cpu_reset_n <= 1'b0;
      r_ready       <= 1'b0;
    end else begin
      r_lock_sync   <= {r_lock_sync[0], LOCKED};
      r_state       <= w_state_next;
      r_filter_cnt  <= w_filter_cnt_next;
      r_hold_cnt    <= w_hold_cnt_next;
      r_sys_reset   <= w_sys_reset_d;
      r_cpu_reset_n <= w_cpu_reset_n_d;
      r_ready       <= w_ready_d;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_filter_cnt_next = r_filter_cnt;
    w_hold_cnt_next   = r_hold_cnt;
    case (r_state)
      ST_WAIT_LOCK: begin
        w_filter_cnt_next = '0;
        w_hold_cnt_next   = '0;
        if (w_locked_s) w_state_next = ST_FILTER;
      end
      ST_FILTER: begin
        if (!w_locked_s) begin
          w_state_next      = ST_WAIT_LOCK;
          w_filter_cnt_next = '0;
        end else if (r_filter_cnt == FILT_LAST) begin
          w_state_next      = ST_HOLD;
          w_filter_cnt_next = '0;
        end else begin
          w_filter_cnt_next = r_filter_cnt + FW'(1);
        end
      end
      ST_HOLD: begin
        if (!w_locked_s) begin
          w_state_next    = ST_WAIT_LOCK;
          w_hold_cnt_next = '0;
        end else if (w_fall_evt) begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_next    = ST_RUN;
            w_hold_cnt_next = '0;
          end else begin
            w_hold_cnt_next = r_hold_cnt + HW'(1);
          end
        end
      end
      ST_RUN: begin
        if (!w_locked_s) w_state_next = ST_WAIT_LOCK;
      end
      default: w_state_next = ST_WAIT_LOCK;
    endcase
  end

  // Outputs are decoded from the next state so they switch with the state register.
  always_comb begin
    w_sys_reset_d   = 1'b1;
    w_cpu_reset_n_d = 1'b0;
    w_ready_d       = 1'b0;
    case (w_state_next)
      ST_HOLD: w_sys_reset_d = 1'b0;
      ST_RUN: begin
        w_sys_reset_d   = 1'b0;
        w_cpu_reset_n_d = 1'b1;
        w_ready_d       = 1'b1;
      end
      default: ;
    endcase
  end

  eq_phase_gen #(.DIV(DIV)) u_eq_phase_gen (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_en       (w_active),
    .i_clr      (w_gen_clr),
    .o_e        (E),
    .o_q        (Q),
    .o_e_rise   (E_RISE),
    .o_e_fall   (E_FALL),
    .o_fall_evt (w_fall_evt)
  );

  assign SYS_RESET   = r_sys_reset;
  assign CPU_RESET_N = r_cpu_reset_n;
  assign READY       = r_ready;

`ifdef RSEQ_LOCK_MONITOR_EN
  logic [7:0] r_loss_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_loss_cnt <= '0;
    else if (w_active && !w_locked_s && (r_loss_cnt != 8'hFF))
      r_loss_cnt <= r_loss_cnt + 8'd1;
  end

  assign LOSS_COUNT = r_loss_cnt;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised bench for pll_reset_sequencer against a closed-form timing model
// (lock run length -> time since HOLD entry -> expected outputs).
module tb_pll_reset_sequencer;
  localparam int F  = 8;
  localparam int H  = 2;
  localparam int D  = 2;
  localparam int EP = 4 * D;
  localparam logic [6:0] RST_VEC = 7'b1000000;

  logic CLK = 1'b0;
  logic RESET;
  logic LOCKED;
  logic SYS_RESET, CPU_RESET_N, E, Q, E_RISE, E_FALL, READY;
`ifdef RSEQ_LOCK_MONITOR_EN
  logic [7:0] LOSS_COUNT;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  // Model: m_k = consecutive edges the synchronised lock has been high.
  int   m_k;
  int   m_loss;
  logic m_h0, m_h1;

  pll_reset_sequencer #(.LOCK_FILTER_CYCLES(F), .RESET_HOLD_CYCLES(H), .DIV(D)) dut (
    .CLK(CLK), .RESET(RESET), .LOCKED(LOCKED),
    .SYS_RESET(SYS_RESET), .CPU_RESET_N(CPU_RESET_N), .E(E), .Q(Q),
    .E_RISE(E_RISE), .E_FALL(E_FALL),
`ifdef RSEQ_LOCK_MONITOR_EN
    .LOSS_COUNT(LOSS_COUNT),
`endif
    .READY(READY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic m_reset();
    m_k = 0; m_h0 = 1'b0; m_h1 = 1'b0; m_loss = 0;
  endtask

  task automatic m_edge();
    logic ls;
    ls = m_h1; m_h1 = m_h0; m_h0 = LOCKED;
    if (ls) m_k++;
    else begin
      if (m_k >= F + 1 && m_loss < 255) m_loss++;
      m_k = 0;
    end
  endtask

  // {SYS_RESET, CPU_RESET_N, E, Q, E_RISE, E_FALL, READY}
  function automatic logic [6:0] m_exp();
    int t, ph;
    logic e, q, er, ef, run;
    t = m_k - (F + 1);
    if (t < 0) return RST_VEC;
    ph  = (3 + t / D) % 4;
    e   = (ph == 1) || (ph == 2);
    q   = (ph == 0) || (ph == 1);
    er  = (t > 0) && (t % D == 0) && (ph == 1);
    ef  = (t > 0) && (t % D == 0) && (ph == 3);
    run = (t >= EP * H);
    return {1'b0, run, e, q, er, ef, run};
  endfunction

  function automatic logic [6:0] obs();
    return {SYS_RESET, CPU_RESET_N, E, Q, E_RISE, E_FALL, READY};
  endfunction

  task automatic cyc();
    @(posedge CLK); #1;
    if (RESET) m_reset(); else m_edge();
  endtask

  task automatic do_reset(input logic lk);
    RESET = 1'b1; LOCKED = lk;
    cyc(); cyc();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; LOCKED = 1'b1;
    #1; m_reset();
    vec_cnt++;
    if (obs() !== RST_VEC) begin
      err_cnt++; $display("FAIL reset_async got=%b exp=%b", obs(), RST_VEC);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      vec_cnt++;
      if (obs() !== RST_VEC) begin
        err_cnt++; $display("FAIL reset_hold i=%0d got=%b exp=%b", i, obs(), RST_VEC);
      end
    end
`ifdef RSEQ_LOCK_MONITOR_EN
    vec_cnt++;
    if (LOSS_COUNT !== 8'd0) begin
      err_cnt++; $display("FAIL reset_loss got=%0d exp=0", LOSS_COUNT);
    end
`endif
    RESET = 1'b0;
  endtask

  task automatic test_lock_sequence();
    int n_sys, n_cpu, n_q, n_e, last_r, last_f;
    n_sys = -1; n_cpu = -1; n_q = -1; n_e = -1; last_r = -1; last_f = -1;
    do_reset(1'b1);
    for (int n = 1; n <= 60; n++) begin
      cyc();
      vec_cnt++;
      if (obs() !== m_exp()) begin
        err_cnt++; $display("FAIL seq_cycle n=%0d got=%b exp=%b", n, obs(), m_exp());
      end
      if (n_sys < 0 && !SYS_RESET) n_sys = n;
      if (n_q < 0 && Q) n_q = n;
      if (n_e < 0 && E) n_e = n;
      if (n_cpu < 0 && CPU_RESET_N) begin
        n_cpu = n;
        vec_cnt++;
        if (!(E_FALL && READY && !E)) begin
          err_cnt++; $display("FAIL cpu_align n=%0d got efall=%b ready=%b e=%b exp 1 1 0", n, E_FALL, READY, E);
        end
      end
      if (E_RISE) begin
        if (last_r >= 0) begin
          vec_cnt++;
          if (n - last_r != EP) begin
            err_cnt++; $display("FAIL rise_period got=%0d exp=%0d", n - last_r, EP);
          end
        end
        last_r = n;
      end
      if (E_FALL) begin
        if (last_f >= 0) begin
          vec_cnt++;
          if (n - last_f != EP) begin
            err_cnt++; $display("FAIL fall_period got=%0d exp=%0d", n - last_f, EP);
          end
        end
        last_f = n;
      end
    end
    vec_cnt++;
    if (n_sys != F + 3) begin
      err_cnt++; $display("FAIL sys_release_edge got=%0d exp=%0d", n_sys, F + 3);
    end
    vec_cnt++;
    if (n_e - n_q != D) begin
      err_cnt++; $display("FAIL q_lead got=%0d exp=%0d", n_e - n_q, D);
    end
    vec_cnt++;
    if (n_cpu - n_sys != EP * H) begin
      err_cnt++; $display("FAIL cpu_release got=%0d exp=%0d", n_cpu - n_sys, EP * H);
    end
  endtask

  task automatic test_filter_glitch();
    int guard, n_sys;
    guard = 0; n_sys = -1;
    do_reset(1'b1);
    while (m_k != 4 && guard < 50) begin
      cyc(); guard++;
    end
    vec_cnt++;
    if (guard >= 50) begin
      err_cnt++; $display("FAIL glitch_setup got=timeout exp=k4");
    end
    LOCKED = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vec_cnt++;
      if (obs() !== m_exp() || !SYS_RESET) begin
        err_cnt++; $display("FAIL glitch_low i=%0d got=%b exp=%b", i, obs(), m_exp());
      end
    end
    LOCKED = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      cyc();
      vec_cnt++;
      if (obs() !== m_exp()) begin
        err_cnt++; $display("FAIL glitch_relock n=%0d got=%b exp=%b", n, obs(), m_exp());
      end
      if (n_sys < 0 && !SYS_RESET) n_sys = n;
    end
    vec_cnt++;
    if (n_sys != F + 3) begin
      err_cnt++; $display("FAIL glitch_refilter got=%0d exp=%0d", n_sys, F + 3);
    end
  endtask

  task automatic test_run_loss();
    int drop_at, n_cpu;
    drop_at = 30 + $urandom_range(0, 15);
    n_cpu = -1;
    do_reset(1'b1);
    for (int n = 1; n <= drop_at; n++) begin
      cyc();
      vec_cnt++;
      if (obs() !== m_exp()) begin
        err_cnt++; $display("FAIL run_cycle n=%0d got=%b exp=%b", n, obs(), m_exp());
      end
    end
    vec_cnt++;
    if (READY !== 1'b1) begin
      err_cnt++; $display("FAIL run_reached got=%b exp=1", READY);
    end
    LOCKED = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      vec_cnt++;
      if (obs() !== m_exp()) begin
        err_cnt++; $display("FAIL loss_cycle i=%0d got=%b exp=%b", i, obs(), m_exp());
      end
      if (i == 2) begin
        vec_cnt++;
        if (obs() !== RST_VEC) begin
          err_cnt++; $display("FAIL loss_3edges got=%b exp=%b", obs(), RST_VEC);
        end
      end
    end
    LOCKED = 1'b1;
    for (int n = 1; n <= 35; n++) begin
      cyc();
      vec_cnt++;
      if (obs() !== m_exp()) begin
        err_cnt++; $display("FAIL relock_cycle n=%0d got=%b exp=%b", n, obs(), m_exp());
      end
      if (n_cpu < 0 && CPU_RESET_N) n_cpu = n;
    end
    vec_cnt++;
    if (n_cpu != F + 3 + EP * H) begin
      err_cnt++; $display("FAIL relock_cpu got=%0d exp=%0d", n_cpu, F + 3 + EP * H);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    for (int n = 1; n <= F + 3 + 5; n++) cyc();
    vec_cnt++;
    if (obs() !== m_exp() || SYS_RESET !== 1'b0 || E !== 1'b1) begin
      err_cnt++; $display("FAIL hold_reached got=%b exp=%b", obs(), m_exp());
    end
    #3; RESET = 1'b1; #1; m_reset();
    vec_cnt++;
    if (obs() !== RST_VEC) begin
      err_cnt++; $display("FAIL async_mid_hold got=%b exp=%b", obs(), RST_VEC);
    end
    cyc();
    vec_cnt++;
    if (obs() !== RST_VEC) begin
      err_cnt++; $display("FAIL async_held got=%b exp=%b", obs(), RST_VEC);
    end
    RESET = 1'b0;
  endtask

  task automatic test_random();
    int seg;
    seg = 0;
    do_reset(1'b0);
    for (int n = 0; n < 2000; n++) begin
      if (seg == 0) begin
        LOCKED = ~LOCKED;
        seg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 60);
      end
      seg--;
      cyc();
      vec_cnt++;
      if (obs() !== m_exp()) begin
        err_cnt++; $display("FAIL rand_cycle n=%0d got=%b exp=%b", n, obs(), m_exp());
      end
`ifdef RSEQ_LOCK_MONITOR_EN
      vec_cnt++;
      if (LOSS_COUNT !== 8'(m_loss)) begin
        err_cnt++; $display("FAIL rand_loss n=%0d got=%0d exp=%0d", n, LOSS_COUNT, m_loss);
      end
`endif
    end
  endtask

`ifdef RSEQ_LOCK_MONITOR_EN
  task automatic test_loss_monitor();
    int hi;
    do_reset(1'b0);
    for (int ev = 0; ev < 300; ev++) begin
      hi = (ev < 3) ? (F + 3 + EP * H + 2 + $urandom_range(0, 6)) : (F + 4);
      LOCKED = 1'b1;
      for (int i = 0; i < hi; i++) cyc();
      if (ev < 3) begin
        vec_cnt++;
        if (READY !== 1'b1) begin
          err_cnt++; $display("FAIL mon_in_run ev=%0d got=%b exp=1", ev, READY);
        end
      end
      LOCKED = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      vec_cnt++;
      if (LOSS_COUNT !== 8'(m_loss)) begin
        err_cnt++; $display("FAIL mon_count ev=%0d got=%0d exp=%0d", ev, LOSS_COUNT, m_loss);
      end
      if (ev == 2) begin
        vec_cnt++;
        if (LOSS_COUNT !== 8'd3) begin
          err_cnt++; $display("FAIL mon_three got=%0d exp=3", LOSS_COUNT);
        end
      end
    end
    vec_cnt++;
    if (LOSS_COUNT !== 8'd255) begin
      err_cnt++; $display("FAIL mon_saturate got=%0d exp=255", LOSS_COUNT);
    end
  endtask
`endif

  initial begin
    m_reset();
    test_reset();
    test_lock_sequence();
    test_filter_glitch();
    test_run_loss();
    test_async_reset();
    test_random();
`ifdef RSEQ_LOCK_MONITOR_EN
    test_loss_monitor();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
